// File: rtl/seg_add_seq.sv
// Wide add/subtract sequencer: feeds one 16-bit segment per cycle, LSB first,
// through an external shared combinational adder and chains the carry in a register.
module seg_add_seq #(
    parameter int NSEG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NSEG-1:0]   in_a,
    input  logic [16*NSEG-1:0]   in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NSEG-1:0]   out_sum,
    output logic                 out_co,
    output logic                 out_ovf,
    output logic                 busy,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_ci,
    input  logic [15:0]          add_s,
    input  logic                 add_co
);
    localparam int W    = 16 * NSEG;
    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SEGW-1:0]   seg_q,   seg_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q,     a_d;
    logic [W-1:0]      b_q,     b_d;
    logic [W-1:0]      res_q,   res_d;

    // Segment views of the latched operands, indexed by the running segment counter.
    logic [15:0] a_seg [NSEG];
    logic [15:0] b_seg [NSEG];

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_seg
            assign a_seg[gi] = a_q[16*gi +: 16];
            assign b_seg[gi] = b_q[16*gi +: 16];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            seg_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    // Subtract as A + ~B + 1; the +1 enters through the initial carry.
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    seg_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NSEG; i++) begin
                    if (seg_q == SEGW'(i)) begin
                        res_d[16*i +: 16] = add_s;
                    end
                end
                carry_d = add_co;
                if (seg_q == SEG_LAST) begin
                    seg_d   = '0;
                    state_d = S_DONE;
                end else begin
                    seg_d = seg_q + SEGW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    assign add_a  = (state_q == S_RUN) ? a_seg[seg_q] : 16'h0000;
    assign add_b  = (state_q == S_RUN) ? b_seg[seg_q] : 16'h0000;
    assign add_ci = (state_q == S_RUN) ? carry_q : 1'b0;

    assign out_sum = res_q;
    assign out_co  = carry_q;
    // Overflow judged against the effective operand B' (already inverted for subtract).
    assign out_ovf = (a_q[W-1] == b_q[W-1]) & (res_q[W-1] != a_q[W-1]);

endmodule
